// File: rtl/reg_arbiter.sv
// reg_arbiter: round-robin arbiter that loads one of NREQ requesters into a
// single shared output register with a valid/ready handshake downstream.
module reg_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid_i,
    input  logic [NREQ*WIDTH-1:0]  req_data_i,
    output logic [NREQ-1:0]        req_ready_o,
    output logic [WIDTH-1:0]       data_o,
    output logic [IDW-1:0]         owner_o,
    output logic                   valid_o,
    input  logic                   ready_i
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  data_q,  data_d;
    logic [IDW-1:0]    owner_q, owner_d;
    logic [IDW-1:0]    ptr_q,   ptr_d;

    logic              accept_c;
    logic              gnt_found_c;
    logic [IDW-1:0]    gnt_idx_c;
    logic [WIDTH-1:0]  gnt_data_c;
    int unsigned       best_dist_c;
    int unsigned       dist_c;

    // A slot is offered when the register is empty or being drained this cycle;
    // never while reset is asserted.
    assign accept_c = rst && ((state_q == EMPTY) || ready_i);

    // Round-robin pick: the valid requester closest to ptr, counting upward with wrap.
    always_comb begin
        gnt_found_c = 1'b0;
        gnt_idx_c   = '0;
        gnt_data_c  = '0;
        best_dist_c = NREQ;
        dist_c      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (i >= 32'(ptr_q)) begin
                dist_c = i - 32'(ptr_q);
            end else begin
                dist_c = i + NREQ - 32'(ptr_q);
            end
            if (req_valid_i[i] && (dist_c < best_dist_c)) begin
                best_dist_c = dist_c;
                gnt_found_c = 1'b1;
                gnt_idx_c   = IDW'(i);
                gnt_data_c  = req_data_i[i*WIDTH +: WIDTH];
            end
        end
        gnt_found_c = gnt_found_c && accept_c;
    end

    // One-hot accept strobe for the winner; doubles as the transfer indication.
    always_comb begin
        req_ready_o = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready_o[i] = gnt_found_c && (32'(gnt_idx_c) == i);
        end
    end

    // Next-state: load on a transfer, drain to EMPTY when consumed with nothing new.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (gnt_found_c) begin
            state_d = FULL;
            data_d  = gnt_data_c;
            owner_d = gnt_idx_c;
            if (32'(gnt_idx_c) == NREQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx_c + IDW'(1);
            end
        end else if ((state_q == FULL) && ready_i) begin
            state_d = EMPTY;
        end
    end

    // State and datapath registers; reset discards any held data immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    assign data_o  = data_q;
    assign owner_o = owner_q;
    assign valid_o = (state_q == FULL);

endmodule
